// File: rtl/matrix_pkg.sv
// Shared constants and helpers for the KxK sliding-window generator.
package matrix_pkg;

    localparam int CNT_W = 16;

    function automatic bit k_legal(input int k);
        return (k == 3) || (k == 5) || (k == 7);
    endfunction

    // Flat element index of window position (r, c); r=0 oldest row, c=0 oldest column.
    function automatic int win_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/matrix_kxk_line_buf.sv
// One line of pixel storage: single address, combinational read, write on we.
// A read and a write to the same address in one cycle return the old contents.
module line_buf #(
    parameter int DEPTH = 30,
    parameter int DW    = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/matrix_kxk.sv
// Streaming KxK window generator over a raster pixel stream with top/left edge handling.
// Define MATRIX_ZERO_PAD_EN to pad out-of-frame rows and left columns with 0 instead of replicating edges.
module matrix_kxk
    import matrix_pkg::*;
#(
    parameter int COL = 30,
    parameter int ROW = 30,
    parameter int K   = 3,
    parameter int DW  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    input  logic               sof_in,
    input  logic [DW-1:0]      din,
    output logic               valid_out,
    output logic [K*K*DW-1:0]  win_data,
    output logic [CNT_W-1:0]   win_row,
    output logic [CNT_W-1:0]   win_col
);

    localparam int AW = (COL > 1) ? $clog2(COL) : 1;

    if (!k_legal(K)) begin : g_bad_k
        $error("matrix_kxk: K must be 3, 5 or 7");
    end

    logic [CNT_W-1:0] col_cnt;
    logic [CNT_W-1:0] row_cnt;
    logic [CNT_W-1:0] cur_col;
    logic [CNT_W-1:0] cur_row;
    logic [DW-1:0]    buf_rd   [K-1];
    logic [DW-1:0]    raw_pix  [K];
    logic [DW-1:0]    new_pix  [K];
    logic [DW-1:0]    win_reg  [K][K];
    logic [DW-1:0]    win_next [K][K];
    logic [CNT_W-1:0] win_row_reg;
    logic [CNT_W-1:0] win_col_reg;
    logic             valid_reg;

    // A start-of-frame pixel is position (0,0) regardless of where the counters are.
    assign cur_col = sof_in ? '0 : col_cnt;
    assign cur_row = sof_in ? '0 : row_cnt;

    assign raw_pix[K-1] = din;

    for (genvar gi = 0; gi < K - 1; gi++) begin : g_lb
        logic [DW-1:0] wdata;
        if (gi == 0) begin : g_first
            assign wdata = din;
        end else begin : g_cascade
            assign wdata = buf_rd[gi-1];
        end

        line_buf #(
            .DEPTH (COL),
            .DW    (DW)
        ) u_line_buf (
            .clk   (clk),
            .we    (valid_in),
            .addr  (cur_col[AW-1:0]),
            .wdata (wdata),
            .rdata (buf_rd[gi])
        );

        assign raw_pix[K-2-gi] = buf_rd[gi];
    end

    // Rows above the frame top never read the (unreset, possibly stale) buffers.
    always_comb begin
`ifndef MATRIX_ZERO_PAD_EN
        logic [DW-1:0] row0_pix;
        row0_pix = din;
        for (int s = 0; s < K; s++) begin
            if (s == K - 1 - int'(cur_row)) begin
                row0_pix = raw_pix[s];
            end
        end
`endif
        for (int r = 0; r < K; r++) begin
            new_pix[r] = raw_pix[r];
            if (int'(cur_row) < K - 1 - r) begin
`ifdef MATRIX_ZERO_PAD_EN
                new_pix[r] = '0;
`else
                new_pix[r] = row0_pix;
`endif
            end
        end
    end

    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_next[r][c] = win_reg[r][c];
                if (valid_in) begin
                    if (cur_col == '0) begin
`ifdef MATRIX_ZERO_PAD_EN
                        win_next[r][c] = (c == K - 1) ? new_pix[r] : '0;
`else
                        win_next[r][c] = new_pix[r];
`endif
                    end else if (c == K - 1) begin
                        win_next[r][c] = new_pix[r];
                    end else begin
                        win_next[r][c] = win_reg[r][(c < K - 1) ? c + 1 : c];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt     <= '0;
            row_cnt     <= '0;
            win_row_reg <= '0;
            win_col_reg <= '0;
            valid_reg   <= 1'b0;
            win_reg     <= '{default: '0};
        end else begin
            valid_reg <= valid_in;
            win_reg   <= win_next;
            if (valid_in) begin
                win_row_reg <= cur_row;
                win_col_reg <= cur_col;
                if (sof_in) begin
                    col_cnt <= CNT_W'(1);
                    row_cnt <= '0;
                end else if (col_cnt == CNT_W'(COL - 1)) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == CNT_W'(ROW - 1)) ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < K; gi++) begin : g_out_r
        for (genvar gj = 0; gj < K; gj++) begin : g_out_c
            assign win_data[win_idx(gi, gj, K)*DW +: DW] = win_reg[gi][gj];
        end
    end

    assign valid_out = valid_reg;
    assign win_row   = win_row_reg;
    assign win_col   = win_col_reg;

endmodule

// File: tb/tb_matrix_kxk.sv
// Self-checking bench: a K=3 4x4 and a K=5 8x8 instance checked against a frame-image window model.
module tb_matrix_kxk;

    localparam int KA = 3, CA = 4, RA = 4;
    localparam int KB = 5, CB = 8, RB = 8;
    localparam int DW = 8;
`ifdef MATRIX_ZERO_PAD_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n = 1'b0, rst_b_n = 1'b0;
    logic va = 1'b0, sa = 1'b0, vb = 1'b0, sb = 1'b0;
    logic [DW-1:0] da = '0, db = '0;
    logic vo_a, vo_b;
    logic [KA*KA*DW-1:0] wd_a;
    logic [KB*KB*DW-1:0] wd_b;
    logic [15:0] wr_a, wc_a, wr_b, wc_b;

    matrix_kxk #(.COL(CA), .ROW(RA), .K(KA), .DW(DW)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .valid_in(va), .sof_in(sa), .din(da),
        .valid_out(vo_a), .win_data(wd_a), .win_row(wr_a), .win_col(wc_a)
    );

    matrix_kxk #(.COL(CB), .ROW(RB), .K(KB), .DW(DW)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .valid_in(vb), .sof_in(sb), .din(db),
        .valid_out(vo_b), .win_data(wd_b), .win_row(wr_b), .win_col(wc_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model state per instance (0 = A, 1 = B): the current frame image and the expected outputs.
    logic [DW-1:0] img [2][8][8];
    int            pr [2];
    int            pc [2];
    logic [255:0]  ew [2];
    int            er [2];
    int            ec [2];
    logic          ev [2];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Element (wr,wc) is the frame pixel K-1-wr rows up and K-1-wc columns left of (r,c);
    // off-frame positions clamp to row/column 0, or read 0 when zero padding.
    function automatic logic [255:0] model_win(input int id, input int k, input int r, input int c);
        logic [255:0] w;
        logic [DW-1:0] p;
        int sr, sc;
        w = '0;
        for (int wr = 0; wr < k; wr++) begin
            for (int wc = 0; wc < k; wc++) begin
                sr = r - (k - 1 - wr);
                sc = c - (k - 1 - wc);
                if (ZP && (sr < 0 || sc < 0)) p = '0;
                else p = img[id][(sr < 0) ? 0 : sr][(sc < 0) ? 0 : sc];
                w[(wr*k+wc)*DW +: DW] = p;
            end
        end
        return w;
    endfunction

    function automatic logic [255:0] pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        logic [255:0] w;
        w = '0;
        w[0*8 +: 8] = 8'(a0); w[1*8 +: 8] = 8'(a1); w[2*8 +: 8] = 8'(a2);
        w[3*8 +: 8] = 8'(a3); w[4*8 +: 8] = 8'(a4); w[5*8 +: 8] = 8'(a5);
        w[6*8 +: 8] = 8'(a6); w[7*8 +: 8] = 8'(a7); w[8*8 +: 8] = 8'(a8);
        return w;
    endfunction

    task automatic advance(input int id, input logic s, input logic [DW-1:0] d);
        int k, cols, rows;
        k    = (id == 0) ? KA : KB;
        cols = (id == 0) ? CA : CB;
        rows = (id == 0) ? RA : RB;
        if (s) begin
            pr[id] = 0;
            pc[id] = 0;
        end
        img[id][pr[id]][pc[id]] = d;
        ew[id] = model_win(id, k, pr[id], pc[id]);
        er[id] = pr[id];
        ec[id] = pc[id];
        pc[id]++;
        if (pc[id] == cols) begin
            pc[id] = 0;
            pr[id] = (pr[id] + 1 == rows) ? 0 : pr[id] + 1;
        end
    endtask

    task automatic compare_all();
        check("A.valid", 256'(vo_a), 256'(ev[0]));
        check("A.win",   256'(wd_a), ew[0]);
        check("A.row",   256'(wr_a), 256'(er[0]));
        check("A.col",   256'(wc_a), 256'(ec[0]));
        check("B.valid", 256'(vo_b), 256'(ev[1]));
        check("B.win",   256'(wd_b), ew[1]);
        check("B.row",   256'(wr_b), 256'(er[1]));
        check("B.col",   256'(wc_b), 256'(ec[1]));
    endtask

    task automatic step(input logic v0, s0, input logic [DW-1:0] d0,
                        input logic v1, s1, input logic [DW-1:0] d1);
        @(negedge clk);
        va = v0; sa = s0; da = d0;
        vb = v1; sb = s1; db = d1;
        @(posedge clk);
        #1;
        cyc++;
        if (v0) advance(0, s0, d0);
        if (v1) advance(1, s1, d1);
        ev[0] = v0;
        ev[1] = v1;
        compare_all();
        $display("[TB] cyc %0d A v=%0b s=%0b d=%0d -> (%0d,%0d)  B v=%0b s=%0b d=%0d -> (%0d,%0d)",
                 cyc, v0, s0, d0, wr_a, wc_a, v1, s1, d1, wr_b, wc_b);
    endtask

    task automatic do_reset(input bit ra, input bit rb);
        @(negedge clk);
        va = 1'b0; vb = 1'b0; sa = 1'b0; sb = 1'b0;
        if (ra) rst_a_n = 1'b0;
        if (rb) rst_b_n = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            ev[i] = 1'b0;
            if ((i == 0 && ra) || (i == 1 && rb)) begin
                ew[i] = '0; er[i] = 0; ec[i] = 0; pr[i] = 0; pc[i] = 0;
            end
        end
        compare_all();
        $display("[TB] cyc %0d reset A=%0b B=%0b", cyc, ra, rb);
        @(negedge clk);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
    endtask

    initial begin
        logic [255:0] held;
        logic v, s;
        for (int i = 0; i < 2; i++) begin
            pr[i] = 0; pc[i] = 0; ew[i] = '0; er[i] = 0; ec[i] = 0; ev[i] = 1'b0;
        end
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    img[i][r][c] = '0;

        repeat (2) @(posedge clk);
        do_reset(1'b1, 1'b1);

        // Frame of 10+index on A, with a 3-cycle gap mid-line of row 1.
        for (int k = 0; k < 10; k++) begin
            step(1'b1, (k == 0), 8'(10 + k), 1'b0, 1'b0, 8'd0);
            if (k == 4) begin
                if (ZP) check("A.edge10", 256'(wd_a), pack9(0, 0, 0, 0, 0, 10, 0, 0, 14));
                else    check("A.edge10", 256'(wd_a), pack9(10, 10, 10, 10, 10, 10, 14, 14, 14));
                check("A.edge10_valid", 256'(vo_a), 256'(1));
            end
            if (k == 5) begin
                held = 256'(wd_a);
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0, 8'd0);
                    check("A.gap_hold", 256'(wd_a), held);
                    check("A.gap_valid", 256'(vo_a), 256'(0));
                end
            end
            if (k == 9) begin
                if (ZP) check("A.win21", 256'(wd_a), pack9(0, 10, 11, 0, 14, 15, 0, 18, 19));
                else    check("A.win21", 256'(wd_a), pack9(10, 10, 11, 14, 14, 15, 18, 18, 19));
                check("A.row21", 256'(wr_a), 256'(2));
                check("A.col21", 256'(wc_a), 256'(1));
            end
        end

        // sof arrives where (2,2) would be: old rows must never reappear.
        for (int k = 0; k < 20; k++) begin
            step(1'b1, (k == 0), 8'(10 + k), 1'b0, 1'b0, 8'd0);
            if (k == 4) begin
                if (ZP) check("A.sof_win", 256'(wd_a), pack9(0, 0, 0, 0, 0, 10, 0, 0, 14));
                else    check("A.sof_win", 256'(wd_a), pack9(10, 10, 10, 10, 10, 10, 14, 14, 14));
            end
        end

        // B: fill to (4,4) of an 8x8 frame of random pixels.
        for (int k = 0; k <= 4 * CB + 4; k++) begin
            step(1'b0, 1'b0, 8'd0, 1'b1, (k == 0), 8'($urandom));
        end
        check("B.win44_row", 256'(wr_b), 256'(4));
        check("B.win44_col", 256'(wc_b), 256'(4));

        // Random traffic on both, with occasional gaps and mid-frame sof.
        for (int n = 0; n < 250; n++) begin
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 39) == 0);
            step(v, s, 8'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 59) == 0), 8'($urandom));
        end

        // Mid-frame reset of B; restart must begin at (0,0) without sof.
        for (int k = 0; k < 13; k++) step(1'b0, 1'b0, 8'd0, 1'b1, (k == 0), 8'($urandom));
        do_reset(1'b0, 1'b1);
        for (int n = 0; n < 120; n++) begin
            step(($urandom_range(0, 3) != 0), 1'b0, 8'($urandom),
                 ($urandom_range(0, 4) != 0), 1'b0, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
